carry_chain_sequencer: RTL and testbench

Sequential multi-precision add stage built around the team's 64-bit ripple-carry add (sum = a + b + cin). Accepts operands one limb per beat, least-significant limb first, over a valid/ready handshake. Chains carry-out of each limb into the next limb's carry-in and registers each limb result for a downstream valid/ready consumer. Extends the 64-bit adder to N×64-bit operands (128/256-bit adds) without widening the combinational carry path.

---
 rtl/carry_chain_sequencer_if.sv | 41 ++++
 rtl/carry_chain_sequencer.sv | 113 +++++++++++
 tb/tb_carry_chain_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/carry_chain_sequencer_if.sv
// Limb-stream bundle for carry_chain_sequencer.
// Purpose: carries the input limb handshake (producer -> stage) and the
// registered result handshake (stage -> consumer).
// Ports (signals):
//   in_valid/in_ready   input limb handshake
//   in_a/in_b           operand limbs, least-significant limb first
//   in_first/in_last    chain framing flags
//   out_valid/out_ready result limb handshake
//   out_sum/out_idx     result limb and its index within the chain
//   out_last/out_carry  final-limb flag and final carry-out of the chain
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both 1. A producer may change or drop its payload only after a transfer;
// the stage never drops a result while out_valid=1 and out_ready=0.
// Modports: master = producer/consumer side (the bench), slave = the stage.
interface carry_chain_sequencer_if #(
    parameter int WIDTH = 64,
    parameter int IDXW  = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_first;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             out_carry;

    modport master (
        output in_valid, in_a, in_b, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_idx, out_last, out_carry
    );

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_idx, out_last, out_carry
    );
endinterface

// File: rtl/carry_chain_sequencer.sv
// Sequential multi-precision adder stage.
// Purpose: adds N x WIDTH-bit operands one limb per beat (LS limb first) with
// a single WIDTH-bit adder, chaining each limb's carry-out into the next
// limb's carry-in and registering every result limb for a downstream
// valid/ready consumer (one-deep output register, one cycle latency).
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        carry_chain_sequencer_if.slave (limb in / result out)
//   err_proto  sticky: chain framing violation (missing or unexpected first)
//   err_len    sticky: chain longer than MAX_LIMBS
//   dbg_state  current FSM state (0 = IDLE, 1 = CHAIN)
module carry_chain_sequencer #(
    parameter int WIDTH     = 64,
    parameter int MAX_LIMBS = 4,
    parameter int IDXW      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    carry_chain_sequencer_if.slave bus,
    output logic                   err_proto,
    output logic                   err_len,
    output logic                   dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        CHAIN = 1'b1
    } state_t;

    localparam logic [IDXW:0] LAST_IDX = (IDXW+1)'(MAX_LIMBS - 1);

    state_t          state, state_nxt;
    logic            carry_reg, carry_nxt;
    logic [IDXW-1:0] cnt, cnt_nxt;

    logic            accept;
    logic            start;
    logic            cin;
    logic            proto_bad;
    logic            len_bad;
    logic [WIDTH:0]  full;
    logic [IDXW:0]   raw_idx;
    logic [IDXW-1:0] idx;

    // Ready is combinational so the register can be refilled in the same
    // cycle it drains; held low while reset is asserted.
    assign bus.in_ready = rst_n & (~bus.out_valid | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign dbg_state    = state;

    always_comb begin
        state_nxt = state;
        carry_nxt = carry_reg;
        cnt_nxt   = cnt;

        // Any limb seen in IDLE starts a chain, as does in_first mid-chain.
        start     = (state == IDLE) | bus.in_first;
        proto_bad = (state == IDLE) ? ~bus.in_first : bus.in_first;
        cin       = start ? 1'b0 : carry_reg;
        full      = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{WIDTH{1'b0}}, cin};

        // One extra bit lets the index run past MAX_LIMBS-1 so overflow can
        // be detected before saturating.
        raw_idx   = start ? '0 : ({1'b0, cnt} + (IDXW+1)'(1));
        len_bad   = (raw_idx > LAST_IDX) | ((raw_idx == LAST_IDX) & ~bus.in_last);
        idx       = (raw_idx > LAST_IDX) ? LAST_IDX[IDXW-1:0] : raw_idx[IDXW-1:0];

        if (accept) begin
            cnt_nxt   = idx;
            carry_nxt = bus.in_last ? 1'b0 : full[WIDTH];
            state_nxt = bus.in_last ? IDLE : CHAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            carry_reg <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            carry_reg <= carry_nxt;
            cnt       <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_idx   <= '0;
            bus.out_last  <= 1'b0;
            bus.out_carry <= 1'b0;
            err_proto     <= 1'b0;
            err_len       <= 1'b0;
        end else begin
            // in_ready=1 means the register is empty or draining this edge.
            if (bus.in_ready) begin
                bus.out_valid <= bus.in_valid;
            end
            if (accept) begin
                bus.out_sum   <= full[WIDTH-1:0];
                bus.out_idx   <= idx;
                bus.out_last  <= bus.in_last;
                bus.out_carry <= bus.in_last & full[WIDTH];
                err_proto     <= err_proto | proto_bad;
                err_len       <= err_len | len_bad;
            end
        end
    end

endmodule

// File: tb/tb_carry_chain_sequencer.sv
// Self-checking bench for carry_chain_sequencer: directed literal vectors
// followed by randomized limb streams, checked every cycle against a
// limb-level arithmetic model and an expected-result queue.
module tb_carry_chain_sequencer;

    localparam int W    = 64;
    localparam int MAXL = 4;
    localparam int IW   = 2;
    localparam int EW   = W + IW + 2;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic err_proto, err_len, dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    carry_chain_sequencer_if #(.WIDTH(W), .IDXW(IW)) bus ();

    carry_chain_sequencer #(.WIDTH(W), .MAX_LIMBS(MAXL), .IDXW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_proto (err_proto),
        .err_len   (err_len),
        .dbg_state (dbg_state)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit run    = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e;
    logic [W:0]    m_full;
    bit            m_in_chain, m_carry, m_ep, m_el, m_start, m_cin, m_exp_ready;
    int            m_pos, m_cnt, m_sidx;

    always @(negedge clk) begin
        if (run) begin
            m_exp_ready = rst_n && ((exp_q.size() == 0) || bus.out_ready);
            chk("in_ready", W'(bus.in_ready), W'(m_exp_ready));
            chk("out_valid", W'(bus.out_valid), W'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("out_sum",   bus.out_sum,          e[EW-1 -: W]);
                chk("out_idx",   W'(bus.out_idx),      W'(e[IW+1:2]));
                chk("out_last",  W'(bus.out_last),     W'(e[1]));
                chk("out_carry", W'(bus.out_carry),    W'(e[0]));
            end
            chk("err_proto", W'(err_proto), W'(m_ep));
            chk("err_len",   W'(err_len),   W'(m_el));

            // Advance the model to what the next rising edge produces.
            if (!rst_n) begin
                exp_q.delete();
                m_in_chain = 0; m_carry = 0; m_cnt = 0; m_ep = 0; m_el = 0;
            end else begin
                if ((exp_q.size() != 0) && bus.out_ready) void'(exp_q.pop_front());
                if (bus.in_valid && m_exp_ready) begin
                    m_start = !m_in_chain || bus.in_first;
                    if (m_in_chain ? bus.in_first : !bus.in_first) m_ep = 1;
                    m_pos = m_start ? 0 : m_cnt + 1;
                    if ((m_pos > MAXL - 1) || ((m_pos == MAXL - 1) && !bus.in_last)) m_el = 1;
                    m_sidx = (m_pos > MAXL - 1) ? MAXL - 1 : m_pos;
                    m_cin  = m_start ? 1'b0 : m_carry;
                    m_full = (W+1)'(bus.in_a) + (W+1)'(bus.in_b) + (W+1)'(m_cin);
                    exp_q.push_back({m_full[W-1:0], IW'(m_sidx), bus.in_last,
                                     bus.in_last & m_full[W]});
                    m_cnt      = m_pos;
                    m_carry    = bus.in_last ? 1'b0 : m_full[W];
                    m_in_chain = !bus.in_last;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic f, input logic l);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        bus.in_first = f;    bus.in_last = l;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) chk("send_timeout", W'(0), W'(1));
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input logic [W-1:0] s, input logic [IW-1:0] idx,
                       input logic l, input logic c);
        chk("lit_valid", W'(bus.out_valid), W'(1));
        chk("lit_sum",   bus.out_sum,       s);
        chk("lit_idx",   W'(bus.out_idx),   W'(idx));
        chk("lit_last",  W'(bus.out_last),  W'(l));
        chk("lit_carry", W'(bus.out_carry), W'(c));
    endtask

    logic [W-1:0] ra, rb;

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0;
        bus.in_first = 0; bus.in_last = 0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_out_sum",   bus.out_sum,       W'(0));
        chk("rst_in_ready",  W'(bus.in_ready),  W'(0));
        chk("rst_err_proto", W'(err_proto),     W'(0));
        chk("rst_err_len",   W'(err_len),       W'(0));
        rst_n = 1'b1;
        run   = 1'b1;

        // Single limb, one cycle latency.
        send(64'h2556DBA11191445A, 64'h71869861DEDE73BB, 1, 1);
        lit(64'h96DD7402F06FB815, 0, 1, 0);

        // Two-limb carry ripple.
        send(ONES, 64'h1, 1, 0);
        lit(64'h0, 0, 0, 0);
        send(64'h0, 64'h0, 0, 1);
        lit(64'h1, 1, 1, 0);

        // All-ones 128-bit add.
        send(ONES, ONES, 1, 0);
        lit(64'hFFFFFFFFFFFFFFFE, 0, 0, 0);
        send(ONES, ONES, 0, 1);
        lit(ONES, 1, 1, 1);

        // Backpressure: hold the first result for 3 cycles.
        idle_cycle();
        bus.out_ready = 1'b0;
        send(ONES, 64'h1, 1, 0);
        bus.in_valid = 1'b1; bus.in_a = '0; bus.in_b = '0;
        bus.in_first = 0;    bus.in_last = 1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", W'(bus.in_ready), W'(0));
            chk("bp_hold_sum", bus.out_sum,      W'(0));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(64'h0, 64'h0, 0, 1);
        lit(64'h1, 1, 1, 0);

        // Framing errors.
        idle_cycle();
        chk("pre_err_proto", W'(err_proto), W'(0));
        send(64'h1, 64'h2, 0, 0);
        lit(64'h3, 0, 0, 0);
        chk("idle_nofirst_err", W'(err_proto), W'(1));
        send(ONES, 64'h1, 0, 0);
        lit(64'h0, 1, 0, 0);
        send(64'h5, 64'h6, 1, 1);
        lit(64'hB, 0, 1, 0);

        // Over-length chain.
        chk("pre_err_len", W'(err_len), W'(0));
        for (int i = 0; i < 5; i++) begin
            send(W'(i), 64'h0, i == 0, i == 4);
            chk("len_idx", W'(bus.out_idx), W'((i > 3) ? 3 : i));
            chk("len_err", W'(err_len),     W'(i >= 3));
        end

        // Reset mid-chain with carry pending.
        send(ONES, 64'h1, 1, 0);
        rst_n = 1'b0;
        idle_cycle();
        chk("mid_rst_valid", W'(bus.out_valid), W'(0));
        chk("mid_rst_idx",   W'(bus.out_idx),   W'(0));
        chk("mid_rst_errp",  W'(err_proto),     W'(0));
        chk("mid_rst_errl",  W'(err_len),       W'(0));
        rst_n = 1'b1;
        send(64'h0, 64'h0, 1, 1);
        lit(64'h0, 0, 1, 0);

        // Randomized streams with gaps, backpressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            case ($urandom_range(0, 3))
                0: ra = ONES;
                1: ra = '0;
                default: ra = {$urandom, $urandom};
            endcase
            rb = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 2)) : {$urandom, $urandom};
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_a      = ra;
            bus.in_b      = rb;
            bus.in_first  = ($urandom_range(0, 3) == 0);
            bus.in_last   = ($urandom_range(0, 2) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst_n         = ($urandom_range(0, 499) != 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1; bus.in_valid = 0; bus.out_ready = 1'b1;
        repeat (4) idle_cycle();
        run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
